// File: rtl/cmp_pkg.sv
// Shared encodings for the sequential magnitude comparator: result codes,
// FSM states and the 7485-style cascade resolution used when all slices match.
package cmp_pkg;

  // Result vectors are ordered {lt, gt, eq}.
  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // All-slices-equal outcome; all-zero cascade inputs give lt=gt=1 by design.
  function automatic logic [2:0] cascade_result(input logic alb_in,
                                                input logic agb_in,
                                                input logic aeb_in);
    return aeb_in ? CMP_EQ : {~agb_in, ~alb_in, 1'b0};
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit unsigned compare; the top time-shares one instance
// across all slices of the operands.
module cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/mag_cmp_seq.sv
// Multi-cycle magnitude comparator: walks the operands SLICE bits per clock,
// most-significant slice first, with optional early exit and cascade inputs.
module mag_cmp_seq
  import cmp_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int SLICE      = 4,
  parameter  int EARLY_EXIT = 1,
  localparam int NSLICE     = WIDTH / SLICE,
  localparam int CNT_W      = $clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             alb_in,
  input  logic             agb_in,
  input  logic             aeb_in,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             agb,
  output logic             aeb,
  output logic [CNT_W-1:0] slices_used
);

  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_d;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cas_alb, cas_agb, cas_aeb;
  logic             decided, dec_lt;
  logic             accept, finish;
  logic [SLICE-1:0] sl_a, sl_b;
  logic             sl_lt, sl_gt, sl_eq;
  logic [2:0]       res;

  assign sl_a = a_q[int'(idx) * SLICE +: SLICE];
  assign sl_b = b_q[int'(idx) * SLICE +: SLICE];

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .lt (sl_lt),
    .gt (sl_gt),
    .eq (sl_eq)
  );

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx == '0 || (EARLY_EXIT != 0 && !sl_eq)) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A recorded decision wins over the current slice, which wins over cascade.
  always_comb begin
    res = cascade_result(cas_alb, cas_agb, cas_aeb);
    if (decided)    res = dec_lt ? CMP_LT : CMP_GT;
    else if (sl_lt) res = CMP_LT;
    else if (sl_gt) res = CMP_GT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cas_alb     <= 1'b0;
      cas_agb     <= 1'b0;
      cas_aeb     <= 1'b0;
      decided     <= 1'b0;
      dec_lt      <= 1'b0;
      done        <= 1'b0;
      alb         <= 1'b0;
      agb         <= 1'b0;
      aeb         <= 1'b0;
      slices_used <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        a_q     <= signed_mode ? (a ^ MSB_MASK) : a;
        b_q     <= signed_mode ? (b ^ MSB_MASK) : b;
        cas_alb <= alb_in;
        cas_agb <= agb_in;
        cas_aeb <= aeb_in;
        idx     <= IDX_W'(NSLICE - 1);
        decided <= 1'b0;
        dec_lt  <= 1'b0;
      end else if (state == ST_RUN) begin
        if (!decided && !sl_eq) begin
          decided <= 1'b1;
          dec_lt  <= sl_lt;
        end
        if (finish) begin
          {alb, agb, aeb} <= res;
          slices_used     <= CNT_W'(NSLICE) - CNT_W'(idx);
          done            <= 1'b1;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Self-checking bench for mag_cmp_seq: one early-exit and one full-run instance
// checked every cycle against a transaction-level model plus directed literals.
module tb_mag_cmp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        signed_mode = 1'b0;
  logic        alb_in = 1'b0;
  logic        agb_in = 1'b0;
  logic        aeb_in = 1'b0;

  logic [1:0]  busy, done, alb, agb, aeb;
  logic [2:0]  used [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0 terminates early, instance 1 always runs all four slices.
  mag_cmp_seq #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(1)) dut_early (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a), .b(b),
    .signed_mode(signed_mode), .alb_in(alb_in), .agb_in(agb_in), .aeb_in(aeb_in),
    .busy(busy[0]), .done(done[0]), .alb(alb[0]), .agb(agb[0]), .aeb(aeb[0]),
    .slices_used(used[0])
  );

  mag_cmp_seq #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a), .b(b),
    .signed_mode(signed_mode), .alb_in(alb_in), .agb_in(agb_in), .aeb_in(aeb_in),
    .busy(busy[1]), .done(done[1]), .alb(alb[1]), .agb(agb[1]), .aeb(aeb[1]),
    .slices_used(used[1])
  );

  // Compare task shared by the per-cycle checker and the directed cases.
  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result from integer arithmetic; slices examined from the highest differing bit.
  function automatic void model_compare(input logic [15:0] av, input logic [15:0] bv,
                                        input logic sm, input logic li, input logic gi,
                                        input logic ei, output logic [2:0] r,
                                        output int j);
    int ia, ib;
    logic [15:0] diff;
    ia = sm ? int'($signed(av)) : int'(av);
    ib = sm ? int'($signed(bv)) : int'(bv);
    if (ia < ib)      r = 3'b100;
    else if (ia > ib) r = 3'b010;
    else              r = {~gi & ~ei, ~li & ~ei, ei};
    diff = av ^ bv;
    j = 4;
    for (int bit_i = 15; bit_i >= 0; bit_i--) begin
      if (diff[bit_i]) begin
        j = 4 - bit_i / 4;
        break;
      end
    end
  endfunction

  logic [1:0] m_busy, m_done;
  logic [2:0] m_res [2];
  logic [2:0] p_res [2];
  int         m_used [2];
  int         p_used [2];
  int         m_left [2];
  logic [2:0] mr;
  int         mj;

  // Transaction model: accept when idle, publish result after the latency.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_res[k]  <= 3'b000;
        p_res[k]  <= 3'b000;
        m_used[k] <= 0;
        p_used[k] <= 0;
        m_left[k] <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (start[k]) begin
            model_compare(a, b, signed_mode, alb_in, agb_in, aeb_in, mr, mj);
            m_busy[k] <= 1'b1;
            p_res[k]  <= mr;
            p_used[k] <= (k == 0) ? mj : 4;
            m_left[k] <= (k == 0) ? mj : 4;
          end
        end else if (m_left[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
          m_res[k]  <= p_res[k];
          m_used[k] <= p_used[k];
        end else begin
          m_left[k] <= m_left[k] - 1;
        end
      end
    end
  end

  // Every-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("cyc_busy%0d", k), int'(busy[k]), int'(m_busy[k]));
      checkOutput($sformatf("cyc_done%0d", k), int'(done[k]), int'(m_done[k]));
      checkOutput($sformatf("cyc_res%0d", k), int'({alb[k], agb[k], aeb[k]}), int'(m_res[k]));
      checkOutput($sformatf("cyc_used%0d", k), int'(used[k]), m_used[k]);
    end
  end

  // Present a request to instance k for exactly one accepting edge.
  task automatic applyStimulus(input int k, input logic [15:0] av, input logic [15:0] bv,
                               input logic sm, input logic [2:0] cas);
    a           = av;
    b           = bv;
    signed_mode = sm;
    {alb_in, agb_in, aeb_in} = cas;
    start[k]    = 1'b1;
    @(posedge clk);
    #1;
    start[k]    = 1'b0;
  endtask

  task automatic waitDone(input int k, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done[k]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic runCase(input string name, input int k, input logic [15:0] av,
                         input logic [15:0] bv, input logic sm, input logic [2:0] cas,
                         input logic [2:0] exp_res, input int exp_used, input int exp_cyc);
    int n;
    applyStimulus(k, av, bv, sm, cas);
    waitDone(k, n);
    checkOutput({name, "_cycles"}, n, exp_cyc);
    checkOutput({name, "_res"}, int'({alb[k], agb[k], aeb[k]}), int'(exp_res));
    checkOutput({name, "_used"}, int'(used[k]), exp_used);
  endtask

  initial begin
    int n;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("reset_busy%0d", k), int'(busy[k]), 0);
      checkOutput($sformatf("reset_res%0d", k), int'({alb[k], agb[k], aeb[k]}), 0);
      checkOutput($sformatf("reset_used%0d", k), int'(used[k]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runCase("u_1234_1235",  0, 16'h1234, 16'h1235, 1'b0, 3'b001, 3'b100, 4, 4);
    runCase("u_8000_0001",  0, 16'h8000, 16'h0001, 1'b0, 3'b001, 3'b010, 1, 1);
    runCase("s_8000_0001",  0, 16'h8000, 16'h0001, 1'b1, 3'b001, 3'b100, 1, 1);
    runCase("eq_aeb_in",    0, 16'hBEEF, 16'hBEEF, 1'b0, 3'b001, 3'b001, 4, 4);
    runCase("eq_alb_in",    0, 16'hBEEF, 16'hBEEF, 1'b0, 3'b100, 3'b100, 4, 4);
    runCase("eq_cas_zero",  0, 16'hBEEF, 16'hBEEF, 1'b0, 3'b000, 3'b110, 4, 4);
    runCase("s_neg_vs_neg", 0, 16'hFFF0, 16'hFF00, 1'b1, 3'b001, 3'b010, 3, 3);

    // Full-run instance with a start pulse mid-run that must be ignored.
    applyStimulus(1, 16'h8000, 16'h0001, 1'b0, 3'b001);
    @(posedge clk);
    #1;
    a        = 16'h0000;
    b        = 16'hFFFF;
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    waitDone(1, n);
    checkOutput("full_cycles", n + 2, 4);
    checkOutput("full_res", int'({alb[1], agb[1], aeb[1]}), int'(3'b010));
    checkOutput("full_used", int'(used[1]), 4);
    checkOutput("full_idle_after", int'(busy[1]), 0);
    runCase("full_cas_zero", 1, 16'hBEEF, 16'hBEEF, 1'b0, 3'b000, 3'b110, 4, 4);

    // Back-to-back: second request issued in the done cycle of the first.
    applyStimulus(0, 16'h1234, 16'h1235, 1'b0, 3'b000);
    waitDone(0, n);
    checkOutput("b2b_first_cycles", n, 4);
    applyStimulus(0, 16'h0002, 16'h0002, 1'b0, 3'b001);
    checkOutput("b2b_busy", int'(busy[0]), 1);
    checkOutput("b2b_held", int'({alb[0], agb[0], aeb[0]}), int'(3'b100));
    waitDone(0, n);
    checkOutput("b2b_second_cycles", n, 4);
    checkOutput("b2b_second_res", int'({alb[0], agb[0], aeb[0]}), int'(3'b001));

    // Reset asserted two cycles into a run aborts it without a done pulse.
    applyStimulus(0, 16'hBEEF, 16'hBEEF, 1'b0, 3'b001);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("abort_busy", int'(busy[0]), 0);
    checkOutput("abort_res", int'({alb[0], agb[0], aeb[0]}), 0);
    checkOutput("abort_used", int'(used[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_done", int'(done[0]), 0);
    end
    runCase("after_abort", 0, 16'h00F0, 16'h0F00, 1'b0, 3'b001, 3'b100, 2, 2);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_cmp_seq.md
# mag_cmp_seq

Parametrised, multi-cycle magnitude comparator that compares two WIDTH-bit operands SLICE bits per clock, most-significant slice first. It supports unsigned and two's-complement modes, optional early termination, and 7485-style cascade inputs for the all-equal case. The block sits in the calculator datapath beside the combinational 4-bit comparator. It serves wide operands (16/32-bit) where a single-cycle comparator cascade is too slow or too large.

## Interface
Parameters:
- WIDTH, 16, operand width; must be a multiple of SLICE.
- SLICE, 4, bits compared per cycle; NSLICE = WIDTH/SLICE.
- EARLY_EXIT, 1, when 1 finish on the first unequal slice; when 0 always run NSLICE cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- signed_mode  in  1  1 = two's-complement compare; captured with operands.
- alb_in, agb_in, aeb_in  in  1 each  cascade inputs; captured with operands.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse; results valid and updated.
- alb, agb, aeb  out  1 each  A<B, A>B, A=B; held until the next done.
- slices_used  out  $clog2(NSLICE+1)  number of slices examined by the last comparison.

## Operation
- States: IDLE, RUN.
- IDLE, start=1: capture a, b, signed_mode and the cascade inputs. Set slice index to NSLICE-1 and clear the "decided" flag. Go to RUN and assert busy.
- Signed mode: invert bit WIDTH-1 of both captured operands, then compare as unsigned.
- RUN, each cycle: compare the current slice of A and B.
  - First unequal slice: record lt/gt and set decided.
  - Later slices never change a decided result.
- RUN exit:
  - EARLY_EXIT=1: exit on the first unequal slice, or after slice 0.
  - EARLY_EXIT=0: always exit after slice 0.
  - Otherwise decrement the index.
- On exit: update alb/agb/aeb and slices_used, pulse done, clear busy, return to IDLE.
- All slices equal, 7485 cascade semantics: aeb = aeb_in; alb = !agb_in & !aeb_in; agb = !alb_in & !aeb_in.
  - Cascade inputs all 0 therefore give alb=agb=1, aeb=0. This is required.
- Decided result: exactly one of alb/agb is 1 and aeb=0. Cascade inputs are ignored.
- start while busy=1 is ignored. No queueing.

## Timing
- Reset values: state IDLE; busy=0, done=0, alb=agb=aeb=0, slices_used=0.
- Accept: start high at edge E0 → busy=1 after E0.
- Latency: with j slices examined (1..NSLICE), the result registers update at edge E0+j. done=1 and busy=0 during the following cycle.
  - EARLY_EXIT=0 gives j=NSLICE always.
- Back-to-back: start may be high in the cycle done=1 (busy=0). It is accepted at the next edge, so there are no dead cycles.
- Outputs are stable from one done to the next, including during RUN.
- rst_n low mid-RUN: immediate abort to reset values. No done pulse; the captured operands are discarded.
- Operand/cascade input changes after the accepting edge have no effect.

## Structure
- Shared package cmp_pkg holds:
  - result encoding localparams (CMP_LT, CMP_GT, CMP_EQ);
  - state encoding (ST_IDLE, ST_RUN).
- Sub-module cmp_slice: combinational SLICE-bit compare with lt/gt/eq outputs, instantiated once and fed by a slice mux.
- Top level holds: FSM, slice index counter, operand registers, decided/result registers, slices_used counter.

## Test plan
All cases use WIDTH=16, SLICE=4 unless stated.
- Unsigned, EARLY_EXIT=1, a=0x1234, b=0x1235 → alb=1, agb=0, aeb=0, slices_used=4, done 4 cycles after the accepting edge.
- a=0x8000, b=0x0001 → unsigned: agb=1, slices_used=1, done after 1 cycle. signed_mode=1: alb=1, slices_used=1.
- a=b=0xBEEF with cascade inputs:
  - aeb_in=1 → aeb=1, alb=agb=0.
  - alb_in=1, aeb_in=0 → alb=1, agb=0.
  - all cascade inputs 0 → alb=agb=1, aeb=0. Each takes 4 cycles.
- EARLY_EXIT=0, a=0x8000, b=0x0001 → agb=1, slices_used=4, done after 4 cycles. A start pulsed mid-run is ignored.
- Back-to-back: second start (a=0x0002, b=0x0002, aeb_in=1) asserted in the done cycle of the first compare → accepted, aeb=1 4 cycles later. Previous results are held until then.
- rst_n low for 1 cycle at cycle 2 of a run → busy=0, all results 0, no done. A new start afterwards completes normally.
